// File: rtl/bus_fabric.sv
// Registered single-master interconnect: decodes the master address into one
// of NUM_SLAVES base/mask windows, drives registered slave strobes, returns a
// one-cycle ready/fault response and keeps a saturating fault count.
//
// state  | meaning
// IDLE   | waiting for a read or write request from the master
// ACTIVE | one slave selected, waiting for its ready or for the timer to expire
// RESP   | ready_out (and fault_out on error) presented to the master for one cycle
module bus_fabric #(
  parameter int                         NUM_SLAVES = 8,
  parameter int                         DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter int                         TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  address_in,
  input  logic                         read_in,
  input  logic                         write_in,
  input  logic [DATA_W/8-1:0]          write_mask_in,
  input  logic [DATA_W-1:0]            write_value_in,
  output logic [DATA_W-1:0]            read_value_out,
  output logic                         ready_out,
  output logic                         fault_out,
  output logic [NUM_SLAVES-1:0]        sel_out,
  output logic [31:0]                  address_out,
  output logic                         read_out,
  output logic [DATA_W/8-1:0]          write_mask_out,
  output logic [DATA_W-1:0]            write_value_out,
  input  logic [NUM_SLAVES*DATA_W-1:0] read_value_in,
  input  logic [NUM_SLAVES-1:0]        ready_in,
  output logic [15:0]                  fault_count_out
);

  localparam int         MASK_W  = DATA_W / 8;
  // The wait timer counts down from TIMEOUT-1; expiry at zero gives exactly
  // TIMEOUT cycles of slave select before the fault response.
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [31:0]           addr_q, addr_d;
  logic                  read_q, read_d;
  logic [MASK_W-1:0]     wmask_q, wmask_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic [15:0]           tmr_q, tmr_d;

  logic [NUM_SLAVES-1:0] hit_vec;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic [DATA_W-1:0]     slave_rdata;
  logic                  slave_ready;
  logic                  req_legal;

  // Window match for every slave against the live master address.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_vec[i] = ((address_in & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign hit_onehot = hit_vec & (~hit_vec + NUM_SLAVES'(1));
  assign req_legal  = (|hit_vec) && !(read_in && write_in);

  // Read data / ready from the selected slave only; unselected slots are masked off.
  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        slave_rdata = slave_rdata | read_value_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign slave_ready = |(ready_in & sel_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    read_d  = read_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    ready_d = 1'b0;
    fault_d = 1'b0;
    fcnt_d  = fcnt_q;
    tmr_d   = tmr_q;

    unique case (state_q)
      IDLE: begin
        if (read_in || write_in) begin
          if (req_legal) begin
            sel_d   = hit_onehot;
            addr_d  = address_in;
            read_d  = read_in;
            wmask_d = write_in ? write_mask_in : '0;
            wdata_d = write_value_in;
            tmr_d   = TMR_LOAD;
            state_d = ACTIVE;
          end else begin
            ready_d = 1'b1;
            fault_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACTIVE: begin
        // Ready takes priority over expiry in the same cycle.
        if (slave_ready) begin
          rdata_d = slave_rdata;
          ready_d = 1'b1;
          sel_d   = '0;
          read_d  = 1'b0;
          wmask_d = '0;
          state_d = RESP;
        end else if (tmr_q == 16'd0) begin
          ready_d = 1'b1;
          fault_d = 1'b1;
          sel_d   = '0;
          read_d  = 1'b0;
          wmask_d = '0;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fault_d && (fcnt_q != 16'hFFFF)) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      fcnt_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      fcnt_q  <= fcnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign sel_out         = sel_q;
  assign address_out     = addr_q;
  assign read_out        = read_q;
  assign write_mask_out  = wmask_q;
  assign write_value_out = wdata_q;
  assign read_value_out  = rdata_q;
  assign ready_out       = ready_q;
  assign fault_out       = fault_q;
  assign fault_count_out = fcnt_q;

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised registered interconnect between one bus master (the arbiter output) and NUM_SLAVES memory-mapped peripherals.
- Replaces the hand-written casez decode and OR-reduced read mux in the SoC top.
- Base/mask address windows are set per slave by parameter.
- Adds behaviour the flat decode lacks: registered one-hot slave select, per-transaction timeout fault, illegal-access fault, and a saturating fault counter.

Parameters:
- NUM_SLAVES, 8: number of slave ports (1..16).
- DATA_W, 32: data width. Write mask width is DATA_W/8.
- SLAVE_BASE, {NUM_SLAVES{32'h0}}: packed array of 32-bit base addresses. Slave i owns window i.
- SLAVE_MASK, {NUM_SLAVES{32'hFFFFFFFF}}: packed array of 32-bit masks. Address hits slave i when (address_in & mask_i) == base_i.
- TIMEOUT, 255: maximum cycles to wait for a slave ready (1..65535).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address_in  in  32  master address, held until ready_out
- read_in  in  1  master read request
- write_in  in  1  master write request
- write_mask_in  in  DATA_W/8  byte enables
- write_value_in  in  DATA_W  write data
- read_value_out  out  DATA_W  read data, valid with ready_out
- ready_out  out  1  one-cycle transaction completion
- fault_out  out  1  one-cycle fault flag, coincident with ready_out
- sel_out  out  NUM_SLAVES  registered one-hot slave select
- address_out  out  32  registered address to slaves
- read_out  out  1  registered read strobe
- write_mask_out  out  DATA_W/8  registered byte enables; zero for reads
- write_value_out  out  DATA_W  registered write data
- read_value_in  in  NUM_SLAVES*DATA_W  slave read data, slot i = bits [i*DATA_W +: DATA_W]
- ready_in  in  NUM_SLAVES  per-slave ready
- fault_count_out  out  16  saturating count of faults since reset

Behaviour:
- Reset (reset_n low at posedge):
  - state = IDLE.
  - All outputs 0: sel_out, read_out, write_mask_out, address_out, write_value_out, read_value_out, ready_out, fault_out, fault_count_out.
  - Reset mid-transaction aborts it. sel_out is low the cycle after the reset edge. No ready_out is issued for the aborted access.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE:
  - On a cycle with read_in | write_in, decode address_in.
  - Lowest-index matching slave wins on overlapping windows.
  - Hit: latch index, address, mask and data. Set sel_out[idx] = 1, read_out = read_in, write_mask_out = write_in ? write_mask_in : 0. Go to ACTIVE.
  - No hit, or read_in & write_in both high: go to RESP with fault; read data = 0; no slave is selected.
- ACTIVE:
  - Timeout counter starts at 0 and increments each cycle.
  - If ready_in[idx] is high: capture read_value_in slot idx, clear sel/read/mask outputs, go to RESP with no fault.
  - Else if counter == TIMEOUT-1: clear sel outputs, go to RESP with fault, read data = 0.
  - Ready on the expiry cycle wins (no fault).
  - ready_in bits of unselected slaves are ignored.
- RESP:
  - ready_out = 1 for exactly one cycle. fault_out = 1 if faulted. read_value_out holds the captured data.
  - Next state is IDLE.
  - read_value_out returns to 0 when ready_out deasserts.
- Latency:
  - Request sampled in IDLE at cycle T, sel_out high T+1.
  - Zero-wait slave (ready combinational on sel): ready_out at T+2.
  - Unmapped access: ready_out at T+1.
  - Timeout: ready_out at T+1+TIMEOUT.
- Back-to-back: a request held high during RESP is not sampled. It is sampled in the following IDLE cycle. Minimum 3 cycles per zero-wait access.
- fault_count_out increments on each fault response and saturates at 16'hFFFF.
- Request signals are ignored in ACTIVE and RESP; latched values are used.

Test Plan:
- Read hit: NUM_SLAVES=4, slave 1 base 32'h00010000 mask 32'hFFFFFFFC, zero-wait, data 32'h000000A5. Read 32'h00010000 at T -> sel_out=4'b0010 at T+1; ready_out=1, fault_out=0, read_value_out=32'h000000A5 at T+2.
- Write with mask: write 32'h00010000, mask 4'b0001, data 32'h12345678 -> at T+1 write_mask_out=4'b0001, write_value_out=32'h12345678, read_out=0; ready_out at T+2.
- Unmapped: read 32'hDEAD0000 -> ready_out=1, fault_out=1, read_value_out=0 at T+1; sel_out never asserts; fault_count_out=1.
- Timeout: TIMEOUT=4, slave never readies -> sel_out high for 4 cycles; ready_out and fault_out at T+5; fault_count_out increments. Variant: ready on the 4th cycle -> no fault.
- Overlap and illegal access: slaves 0 and 2 both match an address -> sel_out=bit0 only. read_in and write_in both high -> fault response at T+1.
- Reset mid-op: deassert reset_n while in ACTIVE -> sel_out=0 next cycle, no ready_out, fault_count_out=0. The next read completes normally.
